// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: cpu memory bus to 128KB RAM / UART bridge.
// Decodes RAM vs I/O, returns read data one cycle after the request,
// buffers tx bytes in a small FIFO with early-full backpressure, and
// exposes a coherent 32-bit cycle counter plus the program-stop flag.
// Optional build macro CPU_IO_STAT_EN adds a status register at 0x30008.
module cpu_io_bridge #(
  parameter int unsigned TX_DEPTH_BIT = 3,
  parameter int unsigned FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_io_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  input  logic        tx_full,
  output logic [7:0]  tx_data,
  output logic        tx_push,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int unsigned DEPTH = 1 << TX_DEPTH_BIT;
  localparam int unsigned CW    = TX_DEPTH_BIT + 1;

  typedef enum logic [2:0] {
    SRC_NONE, SRC_RAM, SRC_RX, SRC_CNT0, SRC_CNT1, SRC_CNT2, SRC_CNT3, SRC_OTHER
  } src_t;

  src_t        src_q, src_nxt;
  logic [7:0]  io_byte_q, io_byte_nxt;
  logic [31:0] cnt_q;
  logic [31:0] snap_q, snap_nxt;

  logic [7:0]              fifo_mem [DEPTH];
  logic [TX_DEPTH_BIT-1:0] head_q, tail_q;
  logic [CW-1:0]           count_q, count_nxt;
  logic                    io_full_q;
  logic                    stop_q, ovf_q;

  logic        io, io_rd, io_wr;
  logic [15:0] io_off;
  logic        fifo_full, push_req, push_ok, drop;
  logic [7:0]  push_data;
  logic        addr_unused;

  assign addr_unused = ^cpu_a[31:18];

  assign io     = (cpu_a[17:16] == 2'b11);
  assign io_off = cpu_a[15:0];
  assign io_rd  = rdy_in & ~cpu_wr & io;
  assign io_wr  = rdy_in &  cpu_wr & io;

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_wr   = cpu_wr & ~io & rdy_in;

  // rx byte is consumed in the request cycle; gated so it is 0 while in reset
  assign rx_pop = rst_in & io_rd & (io_off == 16'h0000) & rx_valid;

  assign cpu_din      = (src_q == SRC_RAM) ? ram_din : io_byte_q;
  assign tx_data      = fifo_mem[head_q];
  assign tx_push      = (count_q != '0) & ~tx_full;
  assign cpu_io_full  = io_full_q;
  assign program_stop = stop_q;
  assign tx_overflow  = ovf_q;

  // Read-source select and I/O byte capture for the cycle-after return
  always_comb begin
    src_nxt     = src_q;
    io_byte_nxt = io_byte_q;
    snap_nxt    = snap_q;
    if (rdy_in && !cpu_wr) begin
      if (!io) begin
        src_nxt = SRC_RAM;
      end else begin
        case (io_off)
          16'h0000: begin
            src_nxt     = SRC_RX;
            io_byte_nxt = rx_valid ? rx_data : 8'h00;
          end
          16'h0004: begin
            src_nxt     = SRC_CNT0;
            io_byte_nxt = cnt_q[7:0];
            snap_nxt    = cnt_q;
          end
          16'h0005: begin
            src_nxt     = SRC_CNT1;
            io_byte_nxt = snap_q[15:8];
          end
          16'h0006: begin
            src_nxt     = SRC_CNT2;
            io_byte_nxt = snap_q[23:16];
          end
          16'h0007: begin
            src_nxt     = SRC_CNT3;
            io_byte_nxt = snap_q[31:24];
          end
`ifdef CPU_IO_STAT_EN
          16'h0008: begin
            src_nxt     = SRC_OTHER;
            io_byte_nxt = {ovf_q, stop_q, 2'b00, 4'(count_q)};
          end
`endif
          default: begin
            src_nxt     = SRC_OTHER;
            io_byte_nxt = 8'h00;
          end
        endcase
      end
    end
  end

  // Tx push decode and FIFO occupancy update
  always_comb begin
    fifo_full = (count_q == CW'(DEPTH));
    push_req  = io_wr & (((io_off == 16'h0000) && (cpu_dout != 8'h00)) ||
                         (io_off == 16'h0004));
    push_data = (io_off == 16'h0004) ? 8'h00 : cpu_dout;
    push_ok   = push_req & (~fifo_full | tx_push);
    drop      = push_req & fifo_full & ~tx_push;
    count_nxt = count_q;
    case ({push_ok, tx_push})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Read-return state, counter and snapshot
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      src_q     <= SRC_NONE;
      io_byte_q <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
    end else begin
      src_q     <= src_nxt;
      io_byte_q <= io_byte_nxt;
      cnt_q     <= cnt_q + 32'd1;
      snap_q    <= snap_nxt;
    end
  end

  // FIFO pointers, occupancy, early-full flag and sticky status bits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      io_full_q <= 1'b0;
      stop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_ok) tail_q <= tail_q + 1'b1;
      if (tx_push) head_q <= head_q + 1'b1;
      count_q   <= count_nxt;
      io_full_q <= ((CW'(DEPTH) - count_nxt) <= CW'(FULL_MARGIN));
      if (io_wr && (io_off == 16'h0004)) stop_q <= 1'b1;
      if (drop) ovf_q <= 1'b1;
`ifdef CPU_IO_STAT_EN
      else if (io_wr && (io_off == 16'h0008)) ovf_q <= 1'b0;
`endif
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[tail_q] <= push_data;
  end

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
Sits directly downstream of the cpu memory bus (byte-wide address, data-out, write and data-in) and in front of the 128KB RAM and the UART.
- Decodes each access as RAM (below 0x20000) or I/O (cpu_a[17:16]==2'b11).
- Steers write data and returns read data exactly one cycle after the request.
- Buffers output bytes in a tx FIFO, supplies cpu_io_full backpressure, exposes a coherent 32-bit cycle counter and the program-stop flag.

Parameters:
TX_DEPTH_BIT, 3, log2 of tx FIFO entries (8 entries)
FULL_MARGIN, 2, cpu_io_full asserted when free entries <= FULL_MARGIN

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  cpu-side accesses ignored when low
cpu_a  input  32  cpu address; bits 17:0 decoded
cpu_dout  input  8  cpu write data
cpu_wr  input  1  1 = write, 0 = read
cpu_din  output  8  read data, valid the cycle after the read request
cpu_io_full  output  1  tx FIFO nearly full, to cpu io_buffer_full
ram_a  output  17  RAM address, cpu_a[16:0]
ram_dout  output  8  RAM write data
ram_wr  output  1  RAM write enable, RAM region only
ram_din  input  8  RAM read data, 1-cycle synchronous latency
rx_valid  input  1  UART rx byte available
rx_data  input  8  UART rx byte
rx_pop  output  1  consume rx byte, 1-cycle pulse
tx_full  input  1  UART tx cannot accept a byte
tx_data  output  8  tx FIFO head
tx_push  output  1  tx_data transferred this cycle
program_stop  output  1  sticky, set by a write to 0x30004
tx_overflow  output  1  sticky, a push was dropped on a full FIFO

Behaviour:
Reset values (rst_in low, asynchronous):
- cpu_din=0, rx_pop=0, tx_push=0, program_stop=0, tx_overflow=0.
- FIFO empty; cycle counter 0; snapshot 0.

Address decode and RAM path:
- io = cpu_a[17:16]==2'b11.
- ram_a=cpu_a[16:0] and ram_dout=cpu_dout, combinational.
- ram_wr = cpu_wr & !io & rdy_in.

Read return:
- At a read cycle with rdy_in high, register the source select: RAM, RX, CNT0..CNT3.
- Next cycle, cpu_din muxes ram_din or a registered I/O byte.
- When rdy_in is low, the select and the I/O byte hold.

I/O reads:
- 0x30000: cpu_din = rx_data if rx_valid, else 0x00. rx_pop pulses in the request cycle only when rx_valid.
- 0x30004: copies the live counter into the snapshot and returns byte 0 of the live counter.
- 0x30005..0x30007: return snapshot bytes 1..3 (little-endian), giving a coherent 32-bit read.

I/O writes (rdy_in high):
- 0x30000 with data != 0: push data.
- 0x30000 with data == 0: ignored.
- 0x30004: push 0x00 and set program_stop.
- Other I/O addresses: ignored.

Counter:
- 32-bit, increments every cycle out of reset, independent of rdy_in.
- Wraps 0xFFFFFFFF -> 0.

Tx FIFO:
- Circular buffer with TX_DEPTH_BIT-bit head and tail pointers plus an (TX_DEPTH_BIT+1)-bit count.
- tx_data = head entry; tx_push = !empty & !tx_full (combinational).
- Pop on a clock edge while tx_push is high.
- Drain continues while rdy_in is low.
- Push while full and not popping: byte dropped, tx_overflow set.
- Push and pop in the same cycle when full: both occur, count unchanged.
- cpu_io_full = (2^TX_DEPTH_BIT - count) <= FULL_MARGIN. Registered, so it reflects the count after the edge.

Reset mid-operation:
- FIFO contents discarded, pending read select cleared, cpu_din returns to 0 immediately.

Optional Feature:
CPU_IO_STAT_EN
- Defined: a read of 0x30008 returns {tx_overflow, program_stop, 2'b0, count[3:0]} (count zero-extended). A write of 0x30008 clears tx_overflow.
- Undefined: 0x30008 reads return 0x00 and writes are ignored; no status logic is built.

Test Plan:
- Write 0x41 to 0x30000, tx_full=0 -> next cycle tx_push=1, tx_data=0x41, for exactly one cycle; FIFO empty afterwards.
- Write 0x00 to 0x30000 -> no tx_push; count stays 0. Write any value to 0x30004 -> program_stop=1, tx_data=0x00 pushed.
- tx_full held high, 6 writes of 0x30..0x35 -> cpu_io_full=1 after the 6th edge. 3 more writes -> 9th byte dropped, tx_overflow=1. Release tx_full -> bytes 0x30..0x37 drained in order.
- Counter at 0x000012FE; read 0x30004..0x30007 on consecutive cycles -> cpu_din sequence 0xFE, 0x12, 0x00, 0x00.
- RAM write 0x5A to 0x00100, then read 0x00100 -> ram_wr=1 only in the write cycle; cpu_din=0x5A one cycle after the read. Same access with rdy_in=0 -> ram_wr stays 0.
- 4 bytes in the FIFO and a read pending; pull rst_in low mid-cycle -> all outputs 0 immediately, FIFO empty, no tx_push after release.
